// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operation sequencer: opcodes, error codes, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package calc_pkg;

  localparam int OPND_W = 4;
  localparam int ERR_W  = 8;

  localparam logic [OPND_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPND_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPND_W-1:0] OP_MUL = 4'h3;
  localparam logic [OPND_W-1:0] OP_DIV = 4'h4;

  localparam logic [ERR_W-1:0] ERR_OP     = 8'h01;
  localparam logic [ERR_W-1:0] ERR_DIV0   = 8'h02;
  localparam logic [ERR_W-1:0] ERR_CMP_TO = 8'h03;
  localparam logic [ERR_W-1:0] ERR_ALU_TO = 8'h04;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_CMP = 3'd2,
    DISPATCH = 3'd3,
    WAIT_ALU = 3'd4,
    RESULT   = 3'd5
  } state_t;

  function automatic logic op_is_legal(input logic [OPND_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Bundle of every handshake/bus signal between the sequencer and its neighbours.
// Latency: n/a (wires only). Ports: keypad side (in_*, nr_coded), complement stage (cmp_*),
// ALU (alu_*), display side (res_*), status (busy). slave = sequencer view, master = environment view.
interface calc_op_sequencer_if #(
  parameter int NR_W  = 4,
  parameter int RES_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3*NR_W-1:0]    nr_coded;

  logic                 cmp_sel;
  logic [3*NR_W-1:0]    cmp_data;
  logic                 cmp_finish;
  logic [NR_W-1:0]      cmp_first;
  logic [NR_W-1:0]      cmp_second;
  logic [NR_W-1:0]      cmp_oper;

  logic                 alu_start;
  logic [NR_W-1:0]      alu_a;
  logic [NR_W-1:0]      alu_b;
  logic [NR_W-1:0]      alu_op;
  logic                 alu_done;
  logic [RES_W-1:0]     alu_result;

  logic                 res_valid;
  logic                 res_ready;
  logic [RES_W-1:0]     res_data;
  logic                 res_err;

  logic                 busy;

  modport slave (
    input  in_valid, nr_coded,
    output in_ready,
    output cmp_sel, cmp_data,
    input  cmp_finish, cmp_first, cmp_second, cmp_oper,
    output alu_start, alu_a, alu_b, alu_op,
    input  alu_done, alu_result,
    output res_valid, res_data, res_err,
    input  res_ready,
    output busy
  );

  modport master (
    output in_valid, nr_coded,
    input  in_ready,
    input  cmp_sel, cmp_data,
    output cmp_finish, cmp_first, cmp_second, cmp_oper,
    input  alu_start, alu_a, alu_b, alu_op,
    output alu_done, alu_result,
    input  res_valid, res_data, res_err,
    output res_ready,
    input  busy
  );

endinterface

// File: rtl/calc_timeout_counter.sv
// Saturating 8-bit wait timer shared by both wait states; timeout_o flags the TIMEOUT_CYC-th waited cycle.
// Latency: timeout_o is combinational from the count register; clear/enable take effect next cycle.
// Backpressure: none. Ports: clk, rst (async active-low), clr_i, en_i, timeout_o.
module calc_timeout_counter #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts the wait cycles already completed, so +1 includes the current
  // one: the state is left after exactly TIMEOUT_CYC cycles of waiting.
  assign timeout_o = (({1'b0, cnt_q} + 9'd1) >= 9'(TIMEOUT_CYC));

endmodule

// File: rtl/calc_op_sequencer.sv
// Control FSM for one calculator operation: accept expression, run complement stage, dispatch to ALU, return result/error.
// Latency: cmp_sel 1 cycle after accept, alu_start Tc+2, res_valid 1 cycle after alu_done; error paths skip the ALU.
// Backpressure: one op in flight; in_ready low while busy; result held in RESULT until res_ready.
// Ports: clk, rst (async active-low), bus (calc_op_sequencer_if.slave, all handshake and data signals).
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int NR_W        = 4,
  parameter int RES_W       = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  calc_op_sequencer_if.slave    bus
);

  state_t               state_q, state_d;
  logic [3*NR_W-1:0]    cmp_data_q, cmp_data_d;
  logic [NR_W-1:0]      alu_a_q, alu_a_d;
  logic [NR_W-1:0]      alu_b_q, alu_b_d;
  logic [NR_W-1:0]      alu_op_q, alu_op_d;
  logic [RES_W-1:0]     res_data_q, res_data_d;
  logic                 res_err_q, res_err_d;
  logic                 fin_prev_q, fin_prev_d;

  logic                 tmr_clr;
  logic                 tmr_en;
  logic                 tmo;
  logic                 cmp_done;
  logic                 op_bad;
  logic                 div_zero;

  logic                 in_ready;
  logic                 cmp_sel;
  logic                 alu_start;
  logic                 res_valid;
  logic                 busy;

  calc_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .timeout_o (tmo)
  );

  assign tmr_clr = (state_q == LOAD) || (state_q == DISPATCH);
  assign tmr_en  = (state_q == WAIT_CMP) || (state_q == WAIT_ALU);

  // The edge register is zero outside LOAD/WAIT_CMP and samples cmp_finish from
  // LOAD onward, so a finish level left high by the previous operation is seen
  // as "already high" in the first wait cycle and must drop before it counts.
  assign fin_prev_d = ((state_q == LOAD) || (state_q == WAIT_CMP)) ? bus.cmp_finish : 1'b0;
  assign cmp_done   = (state_q == WAIT_CMP) && bus.cmp_finish && !fin_prev_q;
  assign op_bad     = !op_is_legal(bus.cmp_oper);
  assign div_zero   = (bus.cmp_oper == OP_DIV) && (bus.cmp_second == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done is tested ahead of timeout so it wins a tie.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (bus.in_valid) state_d = LOAD;
      LOAD:     state_d = WAIT_CMP;
      WAIT_CMP: begin
        if (cmp_done) begin
          state_d = (op_bad || div_zero) ? RESULT : DISPATCH;
        end else if (tmo) begin
          state_d = RESULT;
        end
      end
      DISPATCH: state_d = WAIT_ALU;
      WAIT_ALU: if (bus.alu_done || tmo) state_d = RESULT;
      RESULT:   if (bus.res_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    cmp_sel   = (state_q == LOAD);
    alu_start = (state_q == DISPATCH);
    res_valid = (state_q == RESULT);
    busy      = (state_q != IDLE);
  end

  // Datapath next-state: operand capture and result/error selection.
  always_comb begin
    cmp_data_d = cmp_data_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;

    if ((state_q == IDLE) && bus.in_valid) begin
      cmp_data_d = bus.nr_coded;
    end

    if (cmp_done) begin
      alu_a_d  = bus.cmp_first;
      alu_b_d  = bus.cmp_second;
      alu_op_d = bus.cmp_oper;
      if (op_bad) begin
        res_data_d = RES_W'(ERR_OP);
        res_err_d  = 1'b1;
      end else if (div_zero) begin
        res_data_d = RES_W'(ERR_DIV0);
        res_err_d  = 1'b1;
      end
    end else if ((state_q == WAIT_CMP) && tmo) begin
      res_data_d = RES_W'(ERR_CMP_TO);
      res_err_d  = 1'b1;
    end

    if (state_q == WAIT_ALU) begin
      if (bus.alu_done) begin
        res_data_d = bus.alu_result;
        res_err_d  = 1'b0;
      end else if (tmo) begin
        res_data_d = RES_W'(ERR_ALU_TO);
        res_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_data_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      fin_prev_q <= 1'b0;
    end else begin
      cmp_data_q <= cmp_data_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      fin_prev_q <= fin_prev_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.cmp_sel   = cmp_sel;
  assign bus.cmp_data  = cmp_data_q;
  assign bus.alu_start = alu_start;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: directed and random operations against a cycle-level reference model.
// Latency: n/a. Backpressure: exercised via held-low res_ready and in_valid kept high while busy.
module tb_calc_op_sequencer;
  import calc_pkg::*;

  localparam int RES_W = 8;
  localparam int T     = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;

  calc_op_sequencer_if #(.NR_W(4), .RES_W(RES_W)) bus ();

  calc_op_sequencer #(
    .NR_W        (4),
    .RES_W       (RES_W),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural ALU used by the bench's ALU responder and for the expected result.
  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    case (op)
      4'h1:    return 8'(int'(a) + int'(b));
      4'h2:    return 8'(int'(a) - int'(b));
      4'h3:    return 8'(int'(a) * int'(b));
      4'h4:    return (b == 0) ? 8'h00 : 8'(int'(a) / int'(b));
      default: return 8'h00;
    endcase
  endfunction

  typedef struct {
    bit         exp_alu;
    int         alu_cyc;
    int         res_cyc;
    logic [7:0] data;
    bit         err;
    bit         captured;
  } exp_t;

  // Expected outcome from the operation rules. Cycle 0 is the accept cycle;
  // the complement stage finishes in cycle 1+tc, the ALU answers ta cycles
  // after alu_start, and a timeout fires after T full wait cycles.
  function automatic exp_t predict(input logic [3:0] s, input logic [3:0] o,
                                   input logic [3:0] f, input int tc, input bit cmp_to,
                                   input int ta, input bit alu_to);
    exp_t e;
    int   d;
    e.exp_alu  = 0;
    e.alu_cyc  = -1;
    e.captured = !cmp_to;
    e.err      = 1;
    e.data     = 8'h00;
    d          = 1 + tc;
    if (cmp_to) begin
      e.res_cyc = 2 + T;
      e.data    = 8'h03;
    end else if (!(o >= 4'd1 && o <= 4'd4)) begin
      e.res_cyc = d + 1;
      e.data    = 8'h01;
    end else if (o == 4'd4 && s == 4'd0) begin
      e.res_cyc = d + 1;
      e.data    = 8'h02;
    end else begin
      e.exp_alu = 1;
      e.alu_cyc = d + 1;
      if (alu_to) begin
        e.res_cyc = d + 2 + T;
        e.data    = 8'h04;
      end else begin
        e.res_cyc = d + 2 + ta;
        e.data    = ref_alu(f, s, o);
        e.err     = 0;
      end
    end
    return e;
  endfunction

  task automatic run_op(input logic [11:0] code, input logic [3:0] f, input logic [3:0] s,
                        input logic [3:0] o, input int tc, input bit cmp_to, input int ta,
                        input bit alu_to, input int hold, input bit keep_valid, input int abort_at);
    exp_t       e;
    int         sel_n = 0, sel_cyc = -1, alu_n = 0, alu_cyc = -1, res_cyc = -1;
    int         done_at = -1, fin_at, dd;
    logic [7:0] rdat = 8'h00;
    bit         rerr = 0, stable = 1, rdy_low_ok = 1, busy_ok = 1, aborted = 0;

    e      = predict(s, o, f, tc, cmp_to, ta, alu_to);
    fin_at = cmp_to ? -1 : 1 + tc;
    dd     = (tc > 1) ? $urandom_range(0, tc - 1) : 0;

    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1'b1);
    chk("idle_res_valid", bus.res_valid, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    bus.nr_coded  = code;
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'b0;

    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (keep_valid) bus.nr_coded = 12'($urandom);
      else            bus.in_valid = 1'b0;
      if (!bus.busy) busy_ok = 0;
      if (bus.cmp_sel) begin sel_n++; sel_cyc = k; end
      if (bus.alu_start) begin
        alu_n++;
        alu_cyc = k;
        done_at = alu_to ? -1 : k + ta;
      end
      if (k == abort_at) begin aborted = 1; break; end

      // complement stage responder
      if (k == 1) begin
        bus.cmp_first  = 4'($urandom);
        bus.cmp_second = 4'($urandom);
        bus.cmp_oper   = 4'($urandom);
      end
      if (cmp_to) begin
        if (k == 1) bus.cmp_finish = 1'b1;
      end else begin
        if (k == 1 + dd) bus.cmp_finish = 1'b0;
        if (k == fin_at) begin
          bus.cmp_finish = 1'b1;
          bus.cmp_first  = f;
          bus.cmp_second = s;
          bus.cmp_oper   = o;
        end
      end

      // ALU responder, plus a stray done pulse during LOAD that must be ignored
      bus.alu_done   = (k == done_at);
      bus.alu_result = (k == done_at) ? ref_alu(f, s, o) : 8'($urandom);
      if (k == 1) bus.alu_done = 1'($urandom_range(0, 1));

      if (bus.res_valid) begin
        if (res_cyc < 0) begin
          res_cyc = k;
          rdat    = bus.res_data;
          rerr    = bus.res_err;
        end else if (bus.res_data !== rdat || bus.res_err !== rerr) begin
          stable = 0;
        end
        if (bus.in_ready) rdy_low_ok = 0;
        if (k >= res_cyc + hold) begin
          chk("cmp_data_held", bus.cmp_data, code);
          if (e.captured) begin
            chk("alu_a", bus.alu_a, f);
            chk("alu_b", bus.alu_b, s);
            chk("alu_op", bus.alu_op, o);
          end
          bus.res_ready = 1'b1;
          break;
        end
      end
    end

    if (!aborted) begin
      chk("cmp_sel_cyc", sel_cyc, 1);
      chk("cmp_sel_cnt", sel_n, 1);
      chk("alu_start_cnt", alu_n, e.exp_alu);
      if (e.exp_alu) chk("alu_start_cyc", alu_cyc, e.alu_cyc);
      chk("res_cyc", res_cyc, e.res_cyc);
      chk("res_data", rdat, e.data);
      chk("res_err", rerr, e.err);
      chk("res_stable", stable, 1);
      chk("in_ready_busy", rdy_low_ok, 1);
      chk("busy_high", busy_ok, 1);
    end
  endtask

  initial begin
    logic [11:0] code;
    logic [3:0]  o, s;
    int          seen;

    bus.in_valid   = 1'b0;
    bus.nr_coded   = '0;
    bus.cmp_finish = 1'b0;
    bus.cmp_first  = '0;
    bus.cmp_second = '0;
    bus.cmp_oper   = '0;
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
    bus.res_ready  = 1'b0;

    #3;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_cmp_sel", bus.cmp_sel, 1'b0);
    chk("rst_res_data", bus.res_data, 8'h00);
    chk("rst_cmp_data", bus.cmp_data, 12'h000);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // add, illegal op, divide by zero
    run_op(12'h351, 4'd3, 4'd5, 4'd1, 2, 0, 1, 0, 0, 0, 0);
    run_op(12'h127, 4'd1, 4'd2, 4'd7, 2, 0, 1, 0, 0, 0, 0);
    run_op(12'h804, 4'd8, 4'd0, 4'd4, 2, 0, 1, 0, 0, 0, 0);
    // stale finish never toggled, then ALU never answers
    run_op(12'h351, 4'd3, 4'd5, 4'd1, 2, 1, 1, 0, 0, 0, 0);
    run_op(12'h462, 4'd4, 4'd6, 4'd2, 3, 0, 1, 1, 0, 0, 0);
    // done in the very cycle the timeout would fire
    run_op(12'h733, 4'd7, 4'd3, 4'd3, T, 0, T, 0, 0, 0, 0);
    // back-pressure with in_valid held high throughout, then immediate next accept
    run_op(12'h924, 4'd9, 4'd2, 4'd4, 2, 0, 2, 0, 10, 1, 0);
    run_op(12'h651, 4'd6, 4'd5, 4'd1, 1, 0, 1, 0, 0, 0, 0);

    // reset while in WAIT_ALU
    run_op(12'h351, 4'd3, 4'd5, 4'd1, 2, 0, 1, 1, 0, 0, 7);
    #2 rst = 1'b0;
    #1;
    chk("arst_in_ready", bus.in_ready, 1'b1);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_alu_start", bus.alu_start, 1'b0);
    chk("arst_res_valid", bus.res_valid, 1'b0);
    chk("arst_res_err", bus.res_err, 1'b0);
    chk("arst_res_data", bus.res_data, 8'h00);
    chk("arst_alu_a", bus.alu_a, 4'h0);
    chk("arst_cmp_data", bus.cmp_data, 12'h000);
    bus.in_valid = 1'b0;
    bus.alu_done = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    chk("no_res_after_rst", seen, 0);
    run_op(12'h351, 4'd3, 4'd5, 4'd1, 2, 0, 1, 0, 0, 0, 0);

    // random operations
    for (int n = 0; n < 40; n++) begin
      code = 12'($urandom);
      o    = 4'($urandom_range(0, 6));
      s    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      run_op(code, 4'($urandom), s, o, $urandom_range(1, T), ($urandom_range(0, 9) == 0),
             $urandom_range(1, T), ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 0);
    end

    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("final_in_ready", bus.in_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
